// File: rtl/bmu_pkg.sv
// Shared sizing helpers and FSM state type for the branch metric generator.
package bmu_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int clog2(input int x);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < x) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Widest metric is every code bit at full distance (2**Q-1) from its label bit.
  function automatic int calc_m_w(input int n_out, input int q);
    return clog2(n_out * ((1 << q) - 1) + 1);
  endfunction

  function automatic int calc_s(input int word_w, input int n_out, input int q);
    return word_w / (n_out * q);
  endfunction

  function automatic int calc_l(input int n_out);
    return 1 << n_out;
  endfunction

  function automatic int calc_idx_w(input int s);
    return (clog2(s) < 1) ? 1 : clog2(s);
  endfunction

endpackage

// File: rtl/bm_label_calc.sv
// Combinational branch metrics for every codeword label of one received symbol;
// masked (punctured) code bits contribute nothing to any label.
module bm_label_calc
  import bmu_pkg::*;
#(
  parameter  int N_OUT = 2,
  parameter  int Q     = 1,
  localparam int L     = calc_l(N_OUT),
  localparam int M_W   = calc_m_w(N_OUT, Q)
) (
  input  logic [N_OUT*Q-1:0] sym,
  input  logic [N_OUT-1:0]   mask,
  output logic [L*M_W-1:0]   bm_bus
);

  localparam logic [Q-1:0] E_MAX = '1;

  for (genvar l = 0; l < L; l++) begin : g_label
    logic [M_W-1:0] acc;

    // NOTE: acc gets a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
      acc = '0;
      for (int i = 0; i < N_OUT; i++) begin
        if (mask[i]) begin
          if (((l >> i) & 1) != 0) acc = acc + M_W'(E_MAX - sym[i*Q +: Q]);
          else                     acc = acc + M_W'(sym[i*Q +: Q]);
        end
      end
    end

    assign bm_bus[l*M_W +: M_W] = acc;
  end

endmodule

// File: rtl/branch_metric_gen.sv
// Serialises packed received words into symbols and registers their branch metrics.
// Define PUNCT_EN to add the per-code-bit puncture mask input.
module branch_metric_gen
  import bmu_pkg::*;
#(
  parameter  int WORD_W = 16,
  parameter  int N_OUT  = 2,
  parameter  int Q      = 1,
  localparam int SYM_W  = N_OUT * Q,
  localparam int S      = calc_s(WORD_W, N_OUT, Q),
  localparam int L      = calc_l(N_OUT),
  localparam int M_W    = calc_m_w(N_OUT, Q),
  localparam int IDX_W  = calc_idx_w(S)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_brch,
`ifdef PUNCT_EN
  input  logic [WORD_W/Q-1:0] punct,
`endif
  input  logic [WORD_W-1:0]  data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               bm_valid,
  output logic [L*M_W-1:0]   bm_bus,
  output logic [SYM_W-1:0]   sym_rx,
  output logic [IDX_W-1:0]   sym_idx,
  output logic               word_last
);

  state_t              state;
  logic [WORD_W-1:0]   sr;
  logic [IDX_W-1:0]    cnt;
  logic [N_OUT-1:0]    mask;
  logic [SYM_W-1:0]    sym_cur;
  logic [SYM_W-1:0]    sym_vis;
  logic [L*M_W-1:0]    bm_next;
  logic                advance;
  logic                last_sym;
  logic                accept;

`ifdef PUNCT_EN
  logic [WORD_W/Q-1:0] psr;
  assign mask = psr[WORD_W/Q-1 -: N_OUT];
`else
  assign mask = '1;
`endif

  assign sym_cur = sr[WORD_W-1 -: SYM_W];

  for (genvar i = 0; i < N_OUT; i++) begin : g_vis
    assign sym_vis[i*Q +: Q] = mask[i] ? sym_cur[i*Q +: Q] : '0;
  end

  bm_label_calc #(
    .N_OUT (N_OUT),
    .Q     (Q)
  ) u_calc (
    .sym    (sym_vis),
    .mask   (mask),
    .bm_bus (bm_next)
  );

  assign advance  = (state == SHIFT) && en_brch;
  assign last_sym = (cnt == IDX_W'(S - 1));
  // Ready on the last symbol's cycle lets the next word load with no bubble.
  assign in_ready = (state == IDLE) || (advance && last_sym);
  assign accept   = in_valid && in_ready;

  // NOTE: non-blocking assignments make every register sample pre-edge values; the
  // accept branch comes last so a reload overrides the shift in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      bm_valid  <= 1'b0;
      bm_bus    <= '0;
      sym_rx    <= '0;
      sym_idx   <= '0;
      word_last <= 1'b0;
`ifdef PUNCT_EN
      psr       <= '0;
`endif
    end else begin
      bm_valid  <= advance;
      word_last <= advance && last_sym;
      if (advance) begin
        bm_bus  <= bm_next;
        sym_rx  <= sym_vis;
        sym_idx <= cnt;
        sr      <= sr << SYM_W;
        cnt     <= cnt + IDX_W'(1);
`ifdef PUNCT_EN
        psr     <= psr << N_OUT;
`endif
      end
      if (accept) begin
        state <= SHIFT;
        sr    <= data;
        cnt   <= '0;
`ifdef PUNCT_EN
        psr   <= punct;
`endif
      end else if (advance && last_sym) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_branch_metric_gen.sv
// Scoreboard bench: a hard-decision (default) and a soft Q=2 instance share clk/rst/en_brch.
module tb_branch_metric_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en_brch;

  logic [15:0] data_h;
  logic        in_valid_h, in_ready_h, bm_valid_h, word_last_h;
  logic [7:0]  bm_bus_h;
  logic [1:0]  sym_rx_h;
  logic [2:0]  sym_idx_h;

  logic [15:0] data_s;
  logic        in_valid_s, in_ready_s, bm_valid_s, word_last_s;
  logic [11:0] bm_bus_s;
  logic [3:0]  sym_rx_s;
  logic [1:0]  sym_idx_s;

`ifdef PUNCT_EN
  logic [15:0] punct_h;
  logic [7:0]  punct_s;
`endif

  branch_metric_gen u_hard (
    .clk       (clk),
    .rst       (rst),
    .en_brch   (en_brch),
`ifdef PUNCT_EN
    .punct     (punct_h),
`endif
    .data      (data_h),
    .in_valid  (in_valid_h),
    .in_ready  (in_ready_h),
    .bm_valid  (bm_valid_h),
    .bm_bus    (bm_bus_h),
    .sym_rx    (sym_rx_h),
    .sym_idx   (sym_idx_h),
    .word_last (word_last_h)
  );

  branch_metric_gen #(.WORD_W(16), .N_OUT(2), .Q(2)) u_soft (
    .clk       (clk),
    .rst       (rst),
    .en_brch   (en_brch),
`ifdef PUNCT_EN
    .punct     (punct_s),
`endif
    .data      (data_s),
    .in_valid  (in_valid_s),
    .in_ready  (in_ready_s),
    .bm_valid  (bm_valid_s),
    .bm_bus    (bm_bus_s),
    .sym_rx    (sym_rx_s),
    .sym_idx   (sym_idx_s),
    .word_last (word_last_s)
  );

  typedef struct packed {
    logic [15:0] bm;
    logic [7:0]  sym;
    logic [7:0]  idx;
    logic        last;
  } exp_t;

  exp_t q_h[$];
  exp_t q_s[$];
  exp_t e_h, e_s;

  int total = 0;
  int bad   = 0;
  int run_h = 0;
  int max_run_h = 0;

  // Hand-computed label metrics, label 0 in the low field.
  logic [7:0]  hard_bm  [4] = '{8'h94, 8'h61, 8'h49, 8'h16};   // rx 00,01,10,11
  logic [11:0] soft_bm  [4] = '{12'h633, 12'h6A3, 12'hCD8, 12'h0DE};  // word 16'hC90F
  logic [7:0]  punct_bm [4] = '{8'h00, 8'h11, 8'h05, 8'h16};   // rx 11 under mask 00,01,10,11

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation for every bm_valid cycle of either instance.
  initial begin
    forever begin
      @(negedge clk);
      if (bm_valid_h) begin
        run_h++;
        if (run_h > max_run_h) max_run_h = run_h;
        check("hard_queue_nonempty", (q_h.size() != 0), 1);
        if (q_h.size() != 0) begin
          e_h = q_h.pop_front();
          check("hard_bm", bm_bus_h, e_h.bm);
          check("hard_sym", sym_rx_h, e_h.sym);
          check("hard_idx", sym_idx_h, e_h.idx);
          check("hard_last", word_last_h, e_h.last);
        end
      end else begin
        run_h = 0;
      end
      if (bm_valid_s) begin
        check("soft_queue_nonempty", (q_s.size() != 0), 1);
        if (q_s.size() != 0) begin
          e_s = q_s.pop_front();
          check("soft_bm", bm_bus_s, e_s.bm);
          check("soft_sym", sym_rx_s, e_s.sym);
          check("soft_idx", sym_idx_s, e_s.idx);
          check("soft_last", word_last_s, e_s.last);
        end
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push_h(input logic [15:0] d, input logic [15:0] p, input bit use_p,
                        input int exp_wait);
    int n;
    exp_t e;
    logic [1:0] s;
    logic [1:0] m;
    n = 0;
    data_h = d;
`ifdef PUNCT_EN
    punct_h = p;
`endif
    in_valid_h = 1'b1;
    #1;
    while (!in_ready_h && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("hard_accept", in_ready_h, 1);
    if (exp_wait >= 0) check("hard_ready_wait", n, exp_wait);
    for (int j = 0; j < 8; j++) begin
      s = 2'((d >> (14 - 2*j)) & 16'h3);
      m = 2'((p >> (14 - 2*j)) & 16'h3);
      e.bm   = use_p ? 16'(punct_bm[m]) : 16'(hard_bm[s]);
      e.sym  = use_p ? 8'(m) : 8'(s);
      e.idx  = 8'(j);
      e.last = (j == 7);
      q_h.push_back(e);
    end
    @(negedge clk);
    in_valid_h = 1'b0;
  endtask

  task automatic push_s(input logic [15:0] d);
    int n;
    exp_t e;
    n = 0;
    data_s = d;
    in_valid_s = 1'b1;
    #1;
    while (!in_ready_s && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("soft_accept", in_ready_s, 1);
    for (int j = 0; j < 4; j++) begin
      e.bm   = 16'(soft_bm[j]);
      e.sym  = 8'((d >> (12 - 4*j)) & 16'hF);
      e.idx  = 8'(j);
      e.last = (j == 3);
      q_s.push_back(e);
    end
    @(negedge clk);
    in_valid_s = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_h.size() != 0 || q_s.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_hard", q_h.size(), 0);
    check("drain_soft", q_s.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    en_brch    = 1'b1;
    data_h     = '0;
    data_s     = '0;
    in_valid_h = 1'b0;
    in_valid_s = 1'b0;
`ifdef PUNCT_EN
    punct_h    = '1;
    punct_s    = '1;
`endif
    repeat (2) @(negedge clk);

    check("rst_in_ready_h", in_ready_h, 1);
    check("rst_bm_valid_h", bm_valid_h, 0);
    check("rst_bm_bus_h", bm_bus_h, 0);
    check("rst_sym_rx_h", sym_rx_h, 0);
    check("rst_sym_idx_h", sym_idx_h, 0);
    check("rst_word_last_h", word_last_h, 0);
    check("rst_in_ready_s", in_ready_s, 1);
    check("rst_bm_valid_s", bm_valid_s, 0);
    check("rst_bm_bus_s", bm_bus_s, 0);
    rst = 1'b0;

    // Hard decision, all four received symbols twice.
    push_h(16'h1B1B, 16'hFFFF, 1'b0, -1);
    drain();
    check("idle_in_ready", in_ready_h, 1);

    // Stall for three cycles after idx 2 (symbol 10 -> 8'h49).
    push_h(16'h1B1B, 16'hFFFF, 1'b0, -1);
    repeat (3) @(negedge clk);
    en_brch = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_bm_valid", bm_valid_h, 0);
      check("stall_bm_hold", bm_bus_h, 8'h49);
      check("stall_sym_hold", sym_rx_h, 2'b10);
      check("stall_in_ready", in_ready_h, 0);
    end
    en_brch = 1'b1;
    drain();

    // Back-to-back words: ready only on idx 7, sixteen consecutive valid cycles.
    @(negedge clk);
    max_run_h = 0;
    push_h(16'h1B1B, 16'hFFFF, 1'b0, -1);
    push_h(16'hE4E4, 16'hFFFF, 1'b0, 7);
    check("b2b_ready_low", in_ready_h, 0);
    drain();
    check("b2b_run", max_run_h, 16);

    // Soft decision, Q=2.
    push_s(16'hC90F);
    drain();

    // Reset while idx 4 is on the outputs.
    push_h(16'h1B1B, 16'hFFFF, 1'b0, -1);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    q_h.delete();
    @(negedge clk);
    check("midrst_bm_valid", bm_valid_h, 0);
    check("midrst_in_ready", in_ready_h, 1);
    check("midrst_bm_bus", bm_bus_h, 0);
    check("midrst_sym_rx", sym_rx_h, 0);
    check("midrst_sym_idx", sym_idx_h, 0);
    check("midrst_word_last", word_last_h, 0);
    rst = 1'b0;
    push_h(16'hE4E4, 16'hFFFF, 1'b0, 0);
    drain();

`ifdef PUNCT_EN
    // Received 11 everywhere, masks cycle 10,00,11,01.
    push_h(16'hFFFF, 16'h8D8D, 1'b1, -1);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
